// File: rtl/fpu_norm_sched.sv
// Shared post-normalization engine: round-robin between add/sub (ch0) and mul (ch1).
// Latency: accept in cycle N, result valid in cycle N+2; one result in flight.
// Backpressure: result held in OUT until res_ready; no request accepted while busy.
module fpu_norm_sched #(
  parameter int MW = 24,
  parameter int EW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [MW-1:0] req_mant0,
  input  logic [EW-1:0] req_exp0,
  input  logic [MW-1:0] req_mant1,
  input  logic [EW-1:0] req_exp1,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [MW-1:0] res_mant,
  output logic [7:0]    res_exp,
  output logic          res_src,
  output logic          res_zero,
  output logic          res_denorm,
  output logic          res_ovf
);

  localparam int LZW = $clog2(MW + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, OUT = 2'd2} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last_grant;
  logic          gnt;
  logic          any_req;
  logic          accept;
  logic [MW-1:0] cap_mant;
  logic [EW-1:0] cap_exp;
  logic          cap_src;

  logic [LZW-1:0] lz;
  logic [EW-1:0]  lz_ext;
  logic [EW-1:0]  t_exp;
  logic [EW-1:0]  sub_sh;
  logic           is_zero;
  logic           is_norm;
  logic           is_ovf;
  logic [MW-1:0]  norm_mant;
  logic [MW-1:0]  sub_mant;

  // Round-robin pick: on contention the channel not served last time wins
  always_comb begin
    any_req = |req_valid;
    if (&req_valid) gnt = ~last_grant;
    else            gnt = req_valid[1];
  end

  assign accept = (state == IDLE) && any_req;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> CALC on accept, CALC -> OUT, OUT -> IDLE on result handshake
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = CALC;
      CALC:    state_nxt = OUT;
      OUT:     if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs: ready only for the granted, valid channel while idle
  always_comb begin
    req_ready = 2'b00;
    res_valid = 1'b0;
    case (state)
      IDLE:    if (any_req) req_ready[gnt] = 1'b1;
      OUT:     res_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture the granted request and remember who was served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      cap_src    <= 1'b0;
      cap_mant   <= '0;
      cap_exp    <= '0;
    end else if (accept) begin
      last_grant <= gnt;
      cap_src    <= gnt;
      cap_mant   <= gnt ? req_mant1 : req_mant0;
      cap_exp    <= gnt ? req_exp1  : req_exp0;
    end
  end

  // Leading-zero count; all-zero mantissa yields MW
  always_comb begin
    lz = LZW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (cap_mant[i]) lz = LZW'(MW - 1 - i);
    end
  end

  // Exponent/shift math; subnormals shift only as far as the exponent allows
  always_comb begin
    lz_ext    = EW'(lz);
    is_zero   = (cap_mant == '0);
    is_norm   = (cap_exp > lz_ext);
    t_exp     = cap_exp - lz_ext;
    is_ovf    = is_norm && (t_exp >= EW'(255));
    sub_sh    = (cap_exp == '0) ? '0 : cap_exp - EW'(1);
    norm_mant = cap_mant << lz;
    sub_mant  = cap_mant << sub_sh;
  end

  // Result registers: loaded in CALC, held through OUT and IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_mant   <= '0;
      res_exp    <= '0;
      res_src    <= 1'b0;
      res_zero   <= 1'b0;
      res_denorm <= 1'b0;
      res_ovf    <= 1'b0;
    end else if (state == CALC) begin
      res_src    <= cap_src;
      res_zero   <= is_zero;
      res_ovf    <= !is_zero && is_ovf;
      res_denorm <= !is_zero && !is_norm;
      if (is_zero) begin
        res_mant <= '0;
        res_exp  <= '0;
      end else if (is_norm) begin
        if (is_ovf) begin
          res_mant <= '0;
          res_exp  <= 8'd255;
        end else begin
          res_mant <= norm_mant;
          res_exp  <= t_exp[7:0];
        end
      end else begin
        res_mant <= sub_mant;
        res_exp  <= '0;
      end
    end
  end

endmodule

// File: doc/fpu_norm_sched.md
Name: fpu_norm_sched

Overview:
- Shared post-normalization engine for the FPU. Arbitrates one leading-zero-count and left-shift datapath between two requesters: channel 0 (add/sub unit) and channel 1 (mul unit).
- Takes an unnormalized 24-bit mantissa plus a widened biased exponent.
- Returns a normalized, denormal, zero or overflow result over a valid/ready handshake.
- Sits between the arithmetic cores and the rounding/packing stage.

Parameters:
- MW, 24, mantissa width including hidden bit (MSB is hidden-bit position)
- EW, 9, input exponent width (unsigned biased, headroom above 255)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-channel request valid (bit i = channel i)
- req_ready  out  2  per-channel accept
- req_mant0  in  MW  channel 0 mantissa
- req_exp0  in  EW  channel 0 biased exponent (value when mantissa MSB is bit MW-1)
- req_mant1  in  MW  channel 1 mantissa
- req_exp1  in  EW  channel 1 biased exponent
- res_valid  out  1  result valid
- res_ready  in  1  downstream accept
- res_mant  out  MW  normalized mantissa
- res_exp  out  8  result biased exponent
- res_src  out  1  channel that issued this result
- res_zero  out  1  input mantissa was zero
- res_denorm  out  1  result is subnormal (res_exp=0, mantissa nonzero)
- res_ovf  out  1  exponent overflow; result forced to infinity encoding

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset:
  - State=IDLE. res_valid=0; res_mant=0; res_exp=0; res_src=0; res_zero=0; res_denorm=0; res_ovf=0; req_ready=2'b00.
  - last_grant=1, so channel 0 wins the first contention.
- FSM states: IDLE, CALC, OUT.
  - IDLE: grant is combinational from req_valid and last_grant.
    - Both valid: grant the channel != last_grant.
    - One valid: grant that channel.
    - req_ready[g]=1 only in IDLE, only for the granted channel, only when req_valid[g]=1; the other bit stays 0.
    - On handshake: capture mant/exp/src, update last_grant=g, go to CALC.
  - CALC: one cycle. Internal CLZ of the captured mantissa (0..24, 24 = all zero), shift and exponent math; results registered. Go to OUT.
  - OUT: res_valid=1; all res_* held stable until res_ready=1. On res_valid&res_ready, go to IDLE.
  - No accept in OUT or CALC; req_ready=0.
- Latency and throughput:
  - Handshake in cycle N gives res_valid in cycle N+2.
  - Minimum issue interval is 3 cycles per result (no overlap).
- Arithmetic (lz = CLZ, e = captured exponent, EW bits unsigned):
  - mant==0: res_zero=1; res_mant=0; res_exp=0; denorm=0; ovf=0.
  - e > lz (normal): m' = mant<<lz; t = e-lz.
    - t>=255: res_ovf=1; res_exp=255; res_mant=0.
    - Otherwise res_exp=t[7:0]; res_mant=m'.
  - e <= lz, nonzero (subnormal): shift s = (e==0) ? 0 : e-1; res_mant = mant<<s; res_exp=0; res_denorm=1.
  - Flags are mutually exclusive.
- Boundaries:
  - e-lz==1 is normal, res_exp=1.
  - lz=0 with e=255 is overflow.
  - Requests may drop valid while not granted; no state is kept for ungranted channels.
  - req_valid toggling during CALC/OUT has no effect.
  - res_ready held high gives an OUT duration of exactly 1 cycle.
  - rst_n asserted in any state aborts the transaction immediately; the result is lost, outputs return to reset values asynchronously.

Test Plan:
- Normal: ch0 mant=0x000F00, exp=100, res_ready=1 -> res_valid 2 cycles after accept; res_mant=0xF00000, res_exp=88, res_src=0, all flags 0.
- Subnormal: ch1 mant=0x000100, exp=10 -> res_mant=0x020000, res_exp=0, res_denorm=1, res_src=1; exp=16 with same mant -> res_exp=1, res_mant=0x800000, normal.
- Zero and overflow: mant=0 exp=50 -> res_zero=1, res_exp=0, res_mant=0. mant=0x800000 exp=300 -> res_ovf=1, res_exp=255, res_mant=0.
- Round-robin: both valid continuously from reset, res_ready=1 -> grants 0,1,0,1; res_src alternates; req_ready never 2'b11.
- Backpressure: res_ready=0 for 5 cycles in OUT -> res_* stable, req_ready=2'b00 throughout; accept resumes the cycle after res_ready handshake.
- Reset mid-op: assert rst_n=0 during CALC -> res_valid=0 immediately; after release, a ch0/ch1 simultaneous request grants ch0.
